// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the FPU execute units.
package fpu_pkg;

    localparam int          EXP_W  = 8;
    localparam int          FRAC_W = 23;
    localparam int          BIAS   = 127;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    // Denormals classify as zero: the FPU flushes them on input.
    function automatic fp_class_t classify(input fp32_t x);
        fp_class_t c;
        c.nan  = (x.exp == '1) && (x.frac != '0);
        c.inf  = (x.exp == '1) && (x.frac == '0);
        c.zero = (x.exp == '0);
        return c;
    endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Normalise a 48-bit significand product, round to nearest even and pack
// into binary32, resolving special cases and overflow/underflow.
module fp32_round_pack
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_sum,
    input  logic [47:0]       prod,
    input  logic              is_nan,
    input  logic              is_inf,
    input  logic              is_zero,
    output logic [31:0]       y_next
);

    logic [23:0]        mant;
    logic               guard;
    logic               sticky;
    logic [24:0]        rounded;
    logic signed [10:0] exp_fin;
    logic [FRAC_W-1:0]  frac;
    fp32_t              res;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path through the branches below can infer a latch.
    always_comb begin
        exp_fin = {exp_sum[9], exp_sum};
        mant    = prod[46:23];
        guard   = prod[22];
        sticky  = |prod[21:0];
        if (prod[47]) begin
            mant    = prod[47:24];
            guard   = prod[23];
            sticky  = |prod[22:0];
            exp_fin = exp_fin + 11'sd1;
        end

        rounded = {1'b0, mant} + 25'(guard & (sticky | mant[0]));
        frac    = rounded[22:0];
        if (rounded[24]) begin
            frac    = rounded[23:1];
            exp_fin = exp_fin + 11'sd1;
        end

        res.sign = sign;
        res.exp  = exp_fin[7:0];
        res.frac = frac;

        if (is_nan)
            y_next = QNAN;
        else if (is_inf)
            y_next = {sign, 8'hFF, 23'h0};
        else if (is_zero)
            y_next = {sign, 31'h0};
        else if (exp_fin >= 11'sd255)
            y_next = {sign, 8'hFF, 23'h0};
        else if (exp_fin <= 11'sd0)
            y_next = {sign, 31'h0};
        else
            y_next = res;
    end

endmodule

// File: rtl/fmul_pipe.sv
// Two-stage pipelined binary32 multiplier: unpack/multiply, then round/pack
// into the y register. One result per clock, no handshake.
module fmul_pipe
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    input  logic        clk,
    input  logic        rstn
);

    fp32_t             a, b;
    fp_class_t         ca, cb;
    logic signed [9:0] exp_sum_c;
    logic [47:0]       prod_c;

    logic              s1_sign;
    logic signed [9:0] s1_exp;
    logic [47:0]       s1_prod;
    logic              s1_nan, s1_inf, s1_zero;
    logic [31:0]       y_next;

    assign a  = x1;
    assign b  = x2;
    assign ca = classify(a);
    assign cb = classify(b);

    assign exp_sum_c = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - 10'(BIAS);
    assign prod_c    = {1'b1, a.frac} * {1'b1, b.frac};

    // NOTE: rstn is active-high and synchronous; it clears every pipeline
    // register so in-flight operands are discarded, not just y.
    always_ff @(posedge clk) begin
        if (rstn) begin
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_prod <= '0;
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
            s1_zero <= 1'b0;
            y       <= '0;
        end else begin
            s1_sign <= a.sign ^ b.sign;
            s1_exp  <= exp_sum_c;
            s1_prod <= prod_c;
            // inf * 0 has no defined value, so it joins the NaN class here.
            s1_nan  <= ca.nan | cb.nan | (ca.inf & cb.zero) | (ca.zero & cb.inf);
            s1_inf  <= ca.inf | cb.inf;
            s1_zero <= ca.zero | cb.zero;
            y       <= y_next;
        end
    end

    fp32_round_pack u_round_pack (
        .sign    (s1_sign),
        .exp_sum (s1_exp),
        .prod    (s1_prod),
        .is_nan  (s1_nan),
        .is_inf  (s1_inf),
        .is_zero (s1_zero),
        .y_next  (y_next)
    );

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: a real-arithmetic reference model,
// a per-cycle compare process, directed literal cases and random pairs.
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic [31:0] y;

    int pass_cnt = 0;
    int total_cnt = 0;

    fmul_pipe dut (
        .x1   (x1),
        .x2   (x2),
        .y    (y),
        .clk  (clk),
        .rstn (rstn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total_cnt++;
        if (act === expv)
            pass_cnt++;
        else
            $display("FAIL %s: got %08h, expected %08h", name, act, expv);
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    // Reference: exact product in double, then explicit RNE to 24 bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic       s;
        int         ea, eb, fa, fb, e, r, biased;
        real        m, scaled, rem;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = int'(a[22:0]);
        fb = int'(b[22:0]);
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC0_0000;
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC0_0000;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0) return {s, 31'h0};
        m = (8388608.0 + fa) * pow2(ea - 150) * (8388608.0 + fb) * pow2(eb - 150);
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        scaled = m * 8388608.0;
        r      = $rtoi(scaled);
        rem    = scaled - r;
        if (rem > 0.5 || (rem == 0.5 && (r % 2) == 1)) r++;
        if (r == 16777216) begin r = 8388608; e++; end
        biased = e + 127;
        if (biased >= 255) return {s, 8'hFF, 23'h0};
        if (biased <= 0)   return {s, 31'h0};
        return {s, biased[7:0], 23'(r - 8388608)};
    endfunction

    // History of what the DUT sampled at the last two rising edges.
    logic        h_rst0 = 1'b1, h_rst1 = 1'b1;
    logic [31:0] h_a0 = '0, h_b0 = '0, h_a1 = '0, h_b1 = '0;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        h_rst1 = h_rst0; h_a1 = h_a0; h_b1 = h_b0;
        h_rst0 = rstn;   h_a0 = x1;   h_b0 = x2;
        if (rstn) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            if (h_rst0 || h_rst1)
                check("pipe_reset", y, 32'h0);
            else
                check($sformatf("pipe %08h*%08h", h_a1, h_b1), y, ref_mul(h_a1, h_b1));
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #1;
        x1 = a;
        x2 = b;
    endtask

    // Present a pair, then check the literal result and the model after two edges.
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expv);
        drive(a, b);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        check(name, y, expv);
        check({name, "_model"}, ref_mul(a, b), expv);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 1) == 1) v[30:23] = 8'($urandom_range(100, 154));
        return v;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("reset_y", y, 32'h0);
        #1;
        rstn = 1'b0;

        directed("basic_1p5x2",  32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
        directed("neg2x0p5",     32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000);
        directed("round_lsb",    32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        directed("round_all1",   32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);
        directed("ovf_max_x2",   32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
        directed("unf_min_min",  32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        directed("denorm_flush", 32'h8000_0001, 32'h3F80_0000, 32'h8000_0000);
        directed("inf_x_zero",   32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        directed("nan_in",       32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        directed("neg_inf",      32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
        directed("neg_zero",     32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
        directed("carry_to_inf", 32'h7F7F_FFFF, 32'h3F80_0001, 32'h7F80_0000);

        // Back-to-back pairs, one per cycle; the compare process checks each.
        for (int i = 0; i < 32; i++) drive(rand_fp(), rand_fp());

        // Reset with operands in flight, then release with a constant pair.
        drive(32'h3FC0_0000, 32'h4000_0000);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        #2;
        check("rst_flush", y, 32'h0);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        #2;
        check("rst_hold1", y, 32'h0);
        @(negedge clk);
        #2;
        check("rst_first", y, 32'h4040_0000);

        for (int i = 0; i < 1024; i++) begin
            drive(rand_fp(), rand_fp());
            repeat (7) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
